// File: rtl/impedance_pkg.sv
// ============================================================================
// Module : impedance_pkg
// Brief  : Shared state encoding and constants for the impedance calculator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package impedance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIV_ITER = 48;
    localparam int ANG_HALF = 180;
    localparam int ANG_FULL = 360;

endpackage

`default_nettype wire

// File: rtl/udiv_restoring.sv
// ============================================================================
// Module : udiv_restoring
// Brief  : Serial restoring unsigned divider, one quotient bit per clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module udiv_restoring
    import impedance_pkg::*;
#(
    parameter int DVD_W = 48,
    parameter int DSR_W = 32,
    parameter int CNT_W = 6,
    parameter int ITERS = DIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DSR_W-1:0] i_divisor,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quotient
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(ITERS - 1);

    logic [DSR_W-1:0] r_rem;
    logic [DVD_W-1:0] r_shr;
    logic [DSR_W-1:0] r_dsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [DSR_W-1:0] w_rem_src;
    logic [DVD_W-1:0] w_shr_src;
    logic [DSR_W-1:0] w_dsr_src;
    logic [DSR_W:0]   w_trial;
    logic [DSR_W:0]   w_diff;
    logic             w_fits;
    logic [DSR_W-1:0] w_rem_next;

    // The start cycle already performs the first iteration on the raw inputs,
    // so the final quotient bit lands ITERS edges after start.
    assign w_rem_src  = i_start ? '0 : r_rem;
    assign w_shr_src  = i_start ? i_dividend : r_shr;
    assign w_dsr_src  = i_start ? i_divisor : r_dsr;
    assign w_trial    = {w_rem_src, w_shr_src[DVD_W-1]};
    assign w_diff     = w_trial - {1'b0, w_dsr_src};
    assign w_fits     = (w_trial >= {1'b0, w_dsr_src});
    assign w_rem_next = w_fits ? w_diff[DSR_W-1:0] : w_trial[DSR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_shr  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start || r_busy) begin
                r_rem <= w_rem_next;
                r_shr <= {w_shr_src[DVD_W-2:0], w_fits};
            end
            if (i_start) begin
                r_dsr  <= i_divisor;
                r_cnt  <= CNT_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_cnt == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_shr;

endmodule

`default_nettype wire

// File: rtl/impedance_calc.sv
// ============================================================================
// Module : impedance_calc
// Brief  : Phasor impedance Z = V/I: serial magnitude division plus phase wrap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module impedance_calc
    import impedance_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] v_mag,
    input  logic [31:0] v_ang,
    input  logic [31:0] i_mag,
    input  logic [31:0] i_ang,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] z_mag,
    output logic [31:0] z_ang,
    output logic        div_zero,
    output logic        ovf
);

    localparam logic signed [32:0] c_ang_half = 33'(ANG_HALF);
    localparam logic signed [32:0] c_ang_full = 33'(ANG_FULL);

    state_t r_state;
    state_t w_state_next;

    logic [31:0] r_v_ang;
    logic [31:0] r_i_ang;
    logic        r_dz_op;
    logic [31:0] r_z_mag;
    logic [31:0] r_z_ang;
    logic        r_div_zero;
    logic        r_ovf;

    logic        w_start;
    logic [31:0] w_v_clamp;
    logic [31:0] w_i_clamp;
    logic [47:0] w_dividend;
    logic        w_div_done;
    logic [47:0] w_quot;
    logic        w_sat;
    logic        w_capture;

    logic signed [32:0] w_ang_diff;
    logic signed [32:0] w_ang_wrap;
    logic               w_unused_ang_msb;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_start   = in_valid && in_ready;
    assign w_capture = (r_state == ST_DIV) && w_div_done;

    assign w_v_clamp  = v_mag[31] ? 32'd0 : v_mag;
    assign w_i_clamp  = i_mag[31] ? 32'd0 : i_mag;
    assign w_dividend = {16'd0, w_v_clamp} << FRAC_BITS;

    udiv_restoring #(
        .DVD_W (48),
        .DSR_W (32),
        .CNT_W (CNT_W),
        .ITERS (DIV_ITER)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_i_clamp),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = ST_DIV;
            ST_DIV:  if (w_div_done) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_sat      = |w_quot[47:32];
    assign w_ang_diff = $signed({r_v_ang[31], r_v_ang}) - $signed({r_i_ang[31], r_i_ang});

    always_comb begin
        w_ang_wrap = w_ang_diff;
        if (w_ang_diff > c_ang_half) begin
            w_ang_wrap = w_ang_diff - c_ang_full;
        end else if (w_ang_diff <= -c_ang_half) begin
            w_ang_wrap = w_ang_diff + c_ang_full;
        end
    end

    // The wrapped phase always fits in 32 bits; the guard bit is only needed for the subtract.
    assign w_unused_ang_msb = w_ang_wrap[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_ang    <= '0;
            r_i_ang    <= '0;
            r_dz_op    <= 1'b0;
            r_z_mag    <= '0;
            r_z_ang    <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start) begin
                r_v_ang <= v_ang;
                r_i_ang <= i_ang;
                r_dz_op <= (w_i_clamp == 32'd0);
            end
            if (w_capture) begin
                r_z_ang <= w_ang_wrap[31:0];
                if (r_dz_op) begin
                    r_z_mag    <= 32'hFFFF_FFFF;
                    r_div_zero <= 1'b1;
                    r_ovf      <= 1'b0;
                end else if (w_sat) begin
                    r_z_mag    <= 32'hFFFF_FFFF;
                    r_div_zero <= 1'b0;
                    r_ovf      <= 1'b1;
                end else begin
                    r_z_mag    <= w_quot[31:0];
                    r_div_zero <= 1'b0;
                    r_ovf      <= 1'b0;
                end
            end
        end
    end

    assign z_mag    = r_z_mag;
    assign z_ang    = r_z_ang;
    assign div_zero = r_div_zero;
    assign ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_impedance_calc.sv
// ============================================================================
// Module : tb_impedance_calc
// Brief  : Directed scoreboard bench for impedance_calc.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_impedance_calc;

    typedef struct {
        logic [31:0] z_mag;
        logic [31:0] z_ang;
        logic        dz;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] v_mag = '0;
    logic [31:0] v_ang = '0;
    logic [31:0] i_mag = '0;
    logic [31:0] i_ang = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] z_mag;
    logic [31:0] z_ang;
    logic        div_zero;
    logic        ovf;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];

    impedance_calc #(.FRAC_BITS(16), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .v_mag     (v_mag),
        .v_ang     (v_ang),
        .i_mag     (i_mag),
        .i_ang     (i_ang),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .z_mag     (z_mag),
        .z_ang     (z_ang),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v, input logic [31:0] va,
                                   input logic [31:0] i, input logic [31:0] ia, input int c);
        exp_t        e;
        longint      vv, ii, d;
        longint unsigned q;
        vv = v[31] ? 0 : longint'(v);
        ii = i[31] ? 0 : longint'(i);
        e.dz = 1'b0; e.ovf = 1'b0;
        if (ii == 0) begin
            e.z_mag = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else begin
            q = longint'(unsigned'(vv << 16)) / longint'(unsigned'(ii));
            if (q > 64'h0000_0000_FFFF_FFFF) begin
                e.z_mag = 32'hFFFF_FFFF; e.ovf = 1'b1;
            end else begin
                e.z_mag = q[31:0];
            end
        end
        d = longint'($signed(va)) - longint'($signed(ia));
        if (d > 180) d = d - 360;
        else if (d <= -180) d = d + 360;
        e.z_ang = d[31:0];
        e.acc_cyc = c;
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_z_mag"}, {32'd0, z_mag}, {32'd0, e.z_mag});
        check({tag, "_z_ang"}, {32'd0, z_ang}, {32'd0, e.z_ang});
        check({tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
        check({tag, "_latency"}, 64'(cyc - e.acc_cyc), 64'd49);
    endtask

    // Called at a negedge; the accepting edge is the next posedge.
    task automatic issue(input logic [31:0] v, input logic [31:0] va,
                         input logic [31:0] i, input logic [31:0] ia, input bit push);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk); k++;
        end
        if (!in_ready) check("issue_ready_timeout", 64'd0, 64'd1);
        v_mag = v; v_ang = va; i_mag = i; i_ang = ia; in_valid = 1'b1;
        if (push) sb.push_back(model(v, va, i, ia, cyc));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        logic [31:0] held;
        int k;
        k = 0;
        while (!out_valid && k < 70) begin
            @(negedge clk); k++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        compare_result(tag);
        held = z_mag;
        @(negedge clk);
        check({tag, "_pulse"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_hold"}, {32'd0, z_mag}, {32'd0, held});
    endtask

    task automatic run_op(input string tag, input logic [31:0] v, input logic [31:0] va,
                          input logic [31:0] i, input logic [31:0] ia);
        issue(v, va, i, ia, 1'b1);
        wait_result(tag);
    endtask

    initial begin
        int seen_ov;
        int acc_n, res_n, last_acc, busy_lo;
        bit switch_next, drop_next;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_z_mag", {32'd0, z_mag}, 64'd0);
        check("rst_z_ang", {32'd0, z_ang}, 64'd0);
        check("rst_flags", {62'd0, div_zero, ovf}, 64'd0);

        run_op("basic", 32'd1000, 32'd30, 32'd500, -32'sd10);
        run_op("wrap_pos", 32'd10, 32'd170, 32'd3, -32'sd20);
        run_op("wrap_neg", 32'd10, -32'sd170, 32'd4, 32'd10);
        run_op("div_zero", 32'd1234, 32'd0, 32'd0, 32'd0);
        run_op("sat", 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0);
        run_op("neg_v", -32'sd5, 32'd0, 32'd7, 32'd0);
        run_op("neg_i", 32'd99, 32'd180, -32'sd3, -32'sd180);

        // Reset 20 cycles into a division must suppress its result entirely.
        issue(32'd777, 32'd5, 32'd3, 32'd1, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_z_mag", {32'd0, z_mag}, 64'd0);
        check("abort_z_ang", {32'd0, z_ang}, 64'd0);
        check("abort_flags", {62'd0, div_zero, ovf}, 64'd0);
        seen_ov = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen_ov++;
        end
        check("abort_no_result", 64'(seen_ov), 64'd0);
        run_op("after_abort", 32'd3, 32'd0, 32'd2, 32'd0);

        for (int n = 0; n < 4; n++) begin
            run_op("rand", $urandom, 32'($urandom_range(360)) - 32'd180,
                   32'($urandom_range(2000)), 32'($urandom_range(360)) - 32'd180);
        end

        // in_valid held continuously: accepts must be 50 cycles apart.
        acc_n = 0; res_n = 0; last_acc = 0; busy_lo = 0;
        switch_next = 1'b0; drop_next = 1'b0;
        v_mag = 32'd5000; v_ang = 32'd90; i_mag = 32'd7; i_ang = -32'sd45;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && res_n < 2; n++) begin
            if (out_valid) begin
                compare_result("stream");
                res_n++;
            end
            if (in_valid && in_ready) begin
                if (acc_n > 0) check("stream_spacing", 64'(cyc - last_acc), 64'd50);
                last_acc = cyc;
                sb.push_back(model(v_mag, v_ang, i_mag, i_ang, cyc));
                acc_n++;
                if (acc_n == 1) switch_next = 1'b1;
                else drop_next = 1'b1;
            end else if (in_valid) begin
                busy_lo++;
            end
            @(negedge clk);
            if (switch_next) begin
                v_mag = 32'd12; v_ang = -32'sd100; i_mag = 32'd5; i_ang = 32'd100;
                switch_next = 1'b0;
            end
            if (drop_next) begin
                in_valid = 1'b0;
                drop_next = 1'b0;
            end
        end
        check("stream_accepts", 64'(acc_n), 64'd2);
        check("stream_results", 64'(res_n), 64'd2);
        check("stream_busy_cycles", 64'(busy_lo), 64'd49);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/impedance_calc.md
IMPEDANCE_CALC -- requirements
Module: impedance_calc

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, fractional bits of z_mag.
REQ-002 SHALL have parameter CNT_W, default 6, width of the divider iteration counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present; sampled only when in_ready=1.
REQ-006 SHALL have port v_mag  input  32  signed voltage magnitude, integer units.
REQ-007 SHALL have port v_ang  input  32  signed voltage phase, integer degrees, range [-180,180].
REQ-008 SHALL have port i_mag  input  32  signed current magnitude, integer units.
REQ-009 SHALL have port i_ang  input  32  signed current phase, integer degrees, range [-180,180].
REQ-010 SHALL have port in_ready  output  1  high only in IDLE.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse; result ports valid in that cycle and held until next result.
REQ-012 SHALL have port z_mag  output  32  unsigned |V|/|I|, Q(32-FRAC_BITS).FRAC_BITS.
REQ-013 SHALL have port z_ang  output  32  signed impedance phase, degrees, range (-180,180].
REQ-014 SHALL have port div_zero  output  1  result flag: divisor was 0.
REQ-015 SHALL have port ovf  output  1  result flag: quotient saturated.

Function
REQ-016 SHALL implement FSM IDLE -> DIV -> DONE -> IDLE; IDLE->DIV on in_valid&&in_ready; DIV->DONE after exactly 48 iterations; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL, on acceptance, register operands; negative v_mag/i_mag clamp to 0 before use.
REQ-018 SHALL compute dividend = v_mag<<FRAC_BITS (48-bit unsigned) and divide by i_mag with a restoring divider, one quotient bit per clock, MSB first.
REQ-019 SHALL assert out_valid in the 49th cycle after the accepting edge (DONE state), independent of operand values.
REQ-020 SHALL saturate z_mag to 32'hFFFF_FFFF and set ovf when quotient bits [47:32] are non-zero.
REQ-021 SHALL, when clamped i_mag==0, still run the full 48 iterations, force z_mag=32'hFFFF_FFFF, div_zero=1, ovf=0.
REQ-022 SHALL compute d = v_ang - i_ang in 33-bit signed; z_ang = d-360 if d>180, d+360 if d<=-180, else d.
REQ-023 SHALL ignore in_valid while in DIV or DONE (no queuing, no error).
REQ-024 SHALL update z_mag, z_ang, div_zero, ovf only on entry to DONE; all hold otherwise.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set state=IDLE, counter=0, in_ready=1, out_valid=0, z_mag=0, z_ang=0, div_zero=0, ovf=0.
REQ-026 SHALL abort any division in progress on reset; no out_valid for the aborted operation.
REQ-027 SHALL give rst priority over in_valid in the same cycle.

Structure
REQ-028 SHALL place state encoding (IDLE, DIV, DONE), DIV_ITER=48, ANG_HALF=180, ANG_FULL=360 in shared package impedance_pkg.
REQ-029 SHALL contain one sub-module udiv_restoring (48-bit dividend, 32-bit divisor, start/done, serial) instantiated once; phase wrap and saturation stay in impedance_calc.

Verification
REQ-030 SHALL cover: v_mag=1000, i_mag=500, v_ang=30, i_ang=-10 -> z_mag=32'h0002_0000, z_ang=40, flags 0, out_valid 49 cycles after accept.
REQ-031 SHALL cover: v_ang=170, i_ang=-20 -> z_ang=-170; v_ang=-170, i_ang=10 -> z_ang=180.
REQ-032 SHALL cover: v_mag=1234, i_mag=0 -> z_mag=32'hFFFF_FFFF, div_zero=1, ovf=0, latency 49.
REQ-033 SHALL cover: v_mag=32'h7FFF_FFFF, i_mag=1 -> z_mag=32'hFFFF_FFFF, ovf=1; v_mag=-5, i_mag=7 -> z_mag=0.
REQ-034 SHALL cover: rst pulsed 20 cycles into DIV -> no out_valid, in_ready=1 cycle after reset, outputs 0; next op v_mag=3, i_mag=2 -> z_mag=32'h0001_8000.
REQ-035 SHALL cover: in_valid held high continuously -> accepts every 50 cycles exactly, in_ready low in DIV/DONE, second operand set taken only after DONE.
